// File: rtl/comp_nb_seq_if.sv
// Handshake and operand/result bundle for the digit-serial magnitude comparator.
interface comp_nb_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             aeb;
    logic             agb;
    logic             alb;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, aeb, agb, alb
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, aeb, agb, alb
    );
endinterface

// File: rtl/comp_nb_seq.sv
// Digit-serial (MSB digit first) magnitude comparator, unsigned or two's complement.
// Optional macro COMP_EARLY_EXIT_EN: finish as soon as the first unequal digit is seen.
module comp_nb_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input logic         clk,
    input logic         rst,
    comp_nb_seq_if.slave bus
);
    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               aeb_q, aeb_d;
    logic               agb_q, agb_d;
    logic               alb_q, alb_d;

    // Operands shift left each RUN cycle, so the digit under test is always the top one.
    logic [DIGIT-1:0]   a_dig, b_dig;
    logic               dig_ne, dig_gt;

    assign a_dig  = a_q[WIDTH-1 -: DIGIT];
    assign b_dig  = b_q[WIDTH-1 -: DIGIT];
    assign dig_ne = (a_dig != b_dig);
    assign dig_gt = (a_dig >  b_dig);

`ifndef COMP_EARLY_EXIT_EN
    logic dec_q, dec_d;
    logic gt_q,  gt_d;
    logic fin_dec, fin_gt;

    assign fin_dec = dec_q | dig_ne;
    assign fin_gt  = dec_q ? gt_q : dig_gt;
`endif

    // Next-state, datapath and output decode
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        aeb_d   = aeb_q;
        agb_d   = agb_q;
        alb_d   = alb_q;
`ifndef COMP_EARLY_EXIT_EN
        dec_d   = dec_q;
        gt_d    = gt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    // Flipping the sign bit maps two's complement onto offset binary.
                    a_d     = {bus.a[WIDTH-1] ^ bus.signed_mode, bus.a[WIDTH-2:0]};
                    b_d     = {bus.b[WIDTH-1] ^ bus.signed_mode, bus.b[WIDTH-2:0]};
                    idx_d   = '0;
`ifndef COMP_EARLY_EXIT_EN
                    dec_d   = 1'b0;
                    gt_d    = 1'b0;
`endif
                    state_d = RUN;
                end
            end

            RUN: begin
                a_d   = a_q << DIGIT;
                b_d   = b_q << DIGIT;
                idx_d = idx_q + IDX_W'(1);
`ifdef COMP_EARLY_EXIT_EN
                if (dig_ne) begin
                    aeb_d   = 1'b0;
                    agb_d   = dig_gt;
                    alb_d   = ~dig_gt;
                    state_d = DONE;
                end else if (idx_q == LAST_IDX) begin
                    aeb_d   = 1'b1;
                    agb_d   = 1'b0;
                    alb_d   = 1'b0;
                    state_d = DONE;
                end
`else
                if (!dec_q && dig_ne) begin
                    dec_d = 1'b1;
                    gt_d  = dig_gt;
                end
                if (idx_q == LAST_IDX) begin
                    aeb_d   = ~fin_dec;
                    agb_d   = fin_dec & fin_gt;
                    alb_d   = fin_dec & ~fin_gt;
                    state_d = DONE;
                end
`endif
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            aeb_q   <= 1'b0;
            agb_q   <= 1'b0;
            alb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            aeb_q   <= aeb_d;
            agb_q   <= agb_d;
            alb_q   <= alb_d;
        end
    end

`ifndef COMP_EARLY_EXIT_EN
    // First-difference tracker for the constant-latency build
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q <= 1'b0;
            gt_q  <= 1'b0;
        end else begin
            dec_q <= dec_d;
            gt_q  <= gt_d;
        end
    end
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.aeb  = aeb_q;
    assign bus.agb  = agb_q;
    assign bus.alb  = alb_q;
endmodule
